bcd_to_excess3_serial: RTL and testbench

BCD_TO_EXCESS3_SERIAL -- requirements
Module: bcd_to_excess3_serial

---
 rtl/bcd_to_excess3_serial_pkg.sv | 33 +++
 rtl/bcd_to_excess3_serial_e3_bit_fsm.sv | 70 +++++++
 rtl/bcd_to_excess3_serial.sv | 58 +++++
 tb/tb_bcd_to_excess3_serial.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_excess3_serial_pkg.sv
// Shared definitions for the serial BCD to Excess-3 converter:
// bit-serial FSM state encoding and the Excess-3 offset.
package bcd_to_excess3_serial_pkg;

    // Each state names the bit position expected next and the carry into it.
    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1C0 = 3'd1,
        S1C1 = 3'd2,
        S2C0 = 3'd3,
        S2C1 = 3'd4,
        S3C0 = 3'd5,
        S3C1 = 3'd6
    } e3_state_t;

    localparam logic [3:0] E3_OFFSET = 4'd3;

    function automatic logic [1:0] state_bit_idx(input e3_state_t st);
        logic [1:0] idx;
        case (st)
            S1C0, S1C1: idx = 2'd1;
            S2C0, S2C1: idx = 2'd2;
            S3C0, S3C1: idx = 2'd3;
            default:    idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] excess3_of(input logic [3:0] bcd);
        return bcd + E3_OFFSET;
    endfunction

endpackage

// File: rtl/bcd_to_excess3_serial_e3_bit_fsm.sv
// Bit-serial adder of the constant 3 (addend bits 1,1,0,0, LSB first).
// Holds the state register; Z is Mealy and forced low when En is low.
module e3_bit_fsm
    import bcd_to_excess3_serial_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       X,
    input  logic       En,
    output logic       Z,
    output logic [1:0] Bit_idx
);

    e3_state_t state;
    e3_state_t state_nxt;
    logic      z_raw;

    // Sum bit and carry for X plus the addend bit of the current position.
    always_comb begin
        z_raw     = 1'b0;
        state_nxt = S0;
        case (state)
            S0: begin
                z_raw     = ~X;
                state_nxt = X ? S1C1 : S1C0;
            end
            S1C0: begin
                z_raw     = ~X;
                state_nxt = X ? S2C1 : S2C0;
            end
            S1C1: begin
                z_raw     = X;
                state_nxt = S2C1;
            end
            S2C0: begin
                z_raw     = X;
                state_nxt = S3C0;
            end
            S2C1: begin
                z_raw     = ~X;
                state_nxt = X ? S3C1 : S3C0;
            end
            S3C0: begin
                z_raw     = X;
                state_nxt = S0;
            end
            S3C1: begin
                z_raw     = ~X;
                state_nxt = S0;
            end
            default: begin
                z_raw     = 1'b0;
                state_nxt = S0;
            end
        endcase
    end

    assign Z = En & z_raw;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= S0;
            Bit_idx <= 2'd0;
        end else if (En) begin
            state   <= state_nxt;
            Bit_idx <= state_bit_idx(state_nxt);
        end
    end

endmodule

// File: rtl/bcd_to_excess3_serial.sv
// Serial BCD (LSB first) to Excess-3 converter: streams Z per bit and
// assembles each completed digit into Digit_out with valid/error pulses.
module bcd_to_excess3_serial
    import bcd_to_excess3_serial_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       X,
    input  logic       En,
    output logic       Z,
    output logic [1:0] Bit_idx,
    output logic [3:0] Digit_out,
    output logic       Digit_valid,
    output logic       Err
);

    logic [2:0] shift;
    logic       trk;
    logic       last_bit;
    logic       mid_bit;

    e3_bit_fsm u_fsm (
        .Clk     (Clk),
        .Rst     (Rst),
        .X       (X),
        .En      (En),
        .Z       (Z),
        .Bit_idx (Bit_idx)
    );

    assign last_bit = (Bit_idx == 2'd3);
    assign mid_bit  = (Bit_idx == 2'd1) || (Bit_idx == 2'd2);

    // Shift fills MSB-first so that after bit 2 it holds {z2, z1, z0}.
    // trk flags BCD 10..15 when combined with bit 3.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            shift       <= 3'd0;
            trk         <= 1'b0;
            Digit_out   <= 4'd0;
            Digit_valid <= 1'b0;
            Err         <= 1'b0;
        end else begin
            Digit_valid <= 1'b0;
            Err         <= 1'b0;
            if (En) begin
                shift <= {Z, shift[2:1]};
                trk   <= mid_bit ? (trk | X) : 1'b0;
                if (last_bit) begin
                    Digit_out   <= {Z, shift};
                    Digit_valid <= 1'b1;
                    Err         <= X & trk;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Self-checking bench for bcd_to_excess3_serial: directed literal digits
// plus randomized bit streams compared against an arithmetic model.
module tb_bcd_to_excess3_serial;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       X;
    logic       En;
    logic       Z;
    logic [1:0] Bit_idx;
    logic [3:0] Digit_out;
    logic       Digit_valid;
    logic       Err;

    bcd_to_excess3_serial dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .X           (X),
        .En          (En),
        .Z           (Z),
        .Bit_idx     (Bit_idx),
        .Digit_out   (Digit_out),
        .Digit_valid (Digit_valid),
        .Err         (Err)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;
    int pulses;

    // Model: digit bits collected so far, expected registered outputs.
    logic [1:0] m_idx;
    logic [3:0] m_acc;
    logic [3:0] m_dout;
    logic       m_vld;
    logic       m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare at negedge, then advance the model to what the next posedge yields.
    always @(negedge Clk) begin
        logic [4:0] v;
        logic [4:0] s;
        logic       zexp;
        v    = {1'b0, m_acc} | ({4'b0, X} << m_idx);
        s    = v + 5'd3;
        zexp = En ? s[m_idx] : 1'b0;
        if (chk_on) begin
            check("model_z", 32'(Z), 32'(zexp));
            check("model_bit_idx", 32'(Bit_idx), 32'(m_idx));
            check("model_digit_out", 32'(Digit_out), 32'(m_dout));
            check("model_valid", 32'(Digit_valid), 32'(m_vld));
            check("model_err", 32'(Err), 32'(m_err));
        end
        if (Rst) begin
            m_idx  <= 2'd0;
            m_acc  <= 4'd0;
            m_dout <= 4'd0;
            m_vld  <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_vld <= 1'b0;
            m_err <= 1'b0;
            if (En) begin
                if (m_idx == 2'd3) begin
                    m_dout <= v[3:0] + 4'd3;
                    m_vld  <= 1'b1;
                    m_err  <= (v[3:0] > 4'd9);
                    m_idx  <= 2'd0;
                    m_acc  <= 4'd0;
                end else begin
                    m_acc  <= v[3:0];
                    m_idx  <= m_idx + 2'd1;
                end
            end
        end
    end

    task automatic bit_lit(input logic x, input logic en, input logic zexp, input string nm);
        X  = x;
        En = en;
        #1;
        check(nm, 32'(Z), 32'(zexp));
        @(posedge Clk);
        #1;
    endtask

    task automatic digit_lit(input logic [3:0] d, input logic [3:0] dexp, input logic errexp, input string nm);
        for (int i = 0; i < 4; i++) bit_lit(d[i], 1'b1, dexp[i], {nm, "_z"});
        En = 1'b0;
        check({nm, "_dout"}, 32'(Digit_out), 32'(dexp));
        check({nm, "_valid"}, 32'(Digit_valid), 32'd1);
        check({nm, "_err"}, 32'(Err), 32'(errexp));
        @(posedge Clk);
        #1;
        check({nm, "_valid_drop"}, 32'(Digit_valid), 32'd0);
        check({nm, "_err_drop"}, 32'(Err), 32'd0);
        check({nm, "_dout_hold"}, 32'(Digit_out), 32'(dexp));
    endtask

    initial begin
        Rst = 1'b1;
        X   = 1'b0;
        En  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_on = 1'b1;
        check("rst_bit_idx", 32'(Bit_idx), 32'd0);
        check("rst_dout", 32'(Digit_out), 32'd0);
        check("rst_valid", 32'(Digit_valid), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        X = 1'b1;
        En = 1'b1;
        #1;
        check("rst_z_follows", 32'(Z), 32'd0);
        @(posedge Clk);
        #1;
        check("rst_priority_idx", 32'(Bit_idx), 32'd0);
        Rst = 1'b0;
        En  = 1'b0;
        @(posedge Clk);
        #1;

        digit_lit(4'd0, 4'b0011, 1'b0, "bcd0");
        digit_lit(4'd9, 4'b1100, 1'b0, "bcd9");
        digit_lit(4'd15, 4'b0010, 1'b1, "bcd15");
        digit_lit(4'd8, 4'b1011, 1'b0, "bcd8");

        // All ten digits back to back.
        pulses = 0;
        for (int d = 0; d < 10; d++) begin
            for (int i = 0; i < 4; i++) begin
                logic [3:0] dv;
                dv = 4'(d);
                X  = dv[i];
                En = 1'b1;
                @(posedge Clk);
                #1;
                if (Digit_valid) pulses++;
                if (i == 3) begin
                    check("b2b_valid", 32'(Digit_valid), 32'd1);
                    check("b2b_dout", 32'(Digit_out), 32'(d + 3));
                end
            end
        end
        En = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd10);
        @(posedge Clk);
        #1;

        // 0101 with a three-cycle stall after bit 1.
        bit_lit(1'b1, 1'b1, 1'b0, "stall_z0");
        bit_lit(1'b0, 1'b1, 1'b0, "stall_z1");
        for (int i = 0; i < 3; i++) begin
            bit_lit(1'b1, 1'b0, 1'b0, "stall_z_idle");
            check("stall_bit_idx", 32'(Bit_idx), 32'd2);
            check("stall_no_valid", 32'(Digit_valid), 32'd0);
        end
        bit_lit(1'b1, 1'b1, 1'b0, "stall_z2");
        bit_lit(1'b0, 1'b1, 1'b1, "stall_z3");
        En = 1'b0;
        check("stall_dout", 32'(Digit_out), 32'b1000);
        check("stall_valid", 32'(Digit_valid), 32'd1);
        @(posedge Clk);
        #1;

        // Reset after bit 2 discards the partial digit.
        bit_lit(1'b1, 1'b1, 1'b0, "abort_z0");
        bit_lit(1'b1, 1'b1, 1'b1, "abort_z1");
        bit_lit(1'b1, 1'b1, 1'b0, "abort_z2");
        Rst = 1'b1;
        X   = 1'b0;
        En  = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_bit_idx", 32'(Bit_idx), 32'd0);
        check("abort_no_valid", 32'(Digit_valid), 32'd0);
        check("abort_dout_cleared", 32'(Digit_out), 32'd0);
        Rst = 1'b0;
        En  = 1'b0;
        @(posedge Clk);
        #1;
        check("abort_still_no_valid", 32'(Digit_valid), 32'd0);
        digit_lit(4'd7, 4'b1010, 1'b0, "bcd7");

        // Randomized streams with stalls and occasional resets.
        for (int c = 0; c < 600; c++) begin
            Rst = ($urandom_range(0, 59) == 0);
            En  = ($urandom_range(0, 3) != 0);
            X   = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
        end
        Rst = 1'b0;
        En  = 1'b0;
        @(posedge Clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
